// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: issues sequential word reads to a 1-cycle
// synchronous ROM, buffers returned words with their PCs in a small FIFO,
// and hands them to the core over a valid/ready handshake. A redirect
// flushes everything buffered or in flight and restarts fetch.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          imem_en,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   mem_instr_q [DEPTH];
  logic [31:0]   mem_pc_q [DEPTH];

  logic [CW:0]   used;
  logic          push;
  logic          pop;

  // Credit check counts the in-flight read so a returning word always has a slot.
  always_comb begin
    used      = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    imem_en   = rst & ~redirect_valid & (used < (CW+1)'(DEPTH));
    imem_addr = fetch_pc_q[AW+1:2];
    out_valid = (count_q != '0);
    push      = inflight_q & ~redirect_valid;
    pop       = out_valid & out_ready & ~redirect_valid;
    out_instr = out_valid ? mem_instr_q[rd_ptr_q] : 32'h0;
    out_pc    = out_valid ? mem_pc_q[rd_ptr_q] : 32'h0;
  end

  // Next-state for fetch PC, in-flight tracking and FIFO occupancy; redirect wins.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (imem_en) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // FIFO storage: returned word and its PC land at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr_q[wr_ptr_q] <= imem_rdata;
      mem_pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  // The credit rule must never let a response arrive at a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (count_q == CW'(DEPTH))));

endmodule
